// File: rtl/sr_latch_sequencer_if.sv
// Signal bundle between the SR-latch sequencer, its requesters and the external latch.
interface sr_latch_sequencer_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] op;
    logic [N_REQ-1:0] ack;
    logic             ok;
    logic             err;
    logic             busy;
    logic             s;
    logic             r;
    logic             q;
    logic             q_n;

    modport master (
        output req, op, q, q_n,
        input  ack, ok, err, busy, s, r
    );

    modport slave (
        input  req, op, q, q_n,
        output ack, ok, err, busy, s, r
    );
endinterface

// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer sharing one external SR latch: pulse s/r, settle, read back, ack.
// Optional macro SR_LATCH_RETRY_EN re-drives a failed readback up to MAX_RETRY extra times.
module sr_latch_sequencer #(
    parameter int N_REQ     = 2,
    parameter int PULSE_W   = 2,
    parameter int SETTLE_W  = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sr_latch_sequencer_if.slave   bus
);
    // state  | meaning
    // IDLE   | no operation; arbitrate eligible requests
    // DRIVE  | s or r held high for PULSE_W cycles
    // SETTLE | s=r=0 for SETTLE_W cycles
    // CHECK  | one cycle; readback sampled on its closing edge
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam int MAX_W = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_W - 1);
    localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(N_REQ - 1);

    state_t             r_state, w_nxt_state;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic [PTR_W-1:0]   r_ptr, w_nxt_ptr;
    logic               r_op, w_nxt_op;
    logic               r_s, w_nxt_s;
    logic               r_r, w_nxt_r;
    logic [N_REQ-1:0]   r_ack, w_nxt_ack;
    logic               r_ok, w_nxt_ok;
    logic               r_err, w_nxt_err;
    logic               r_busy;

    logic [N_REQ-1:0]   w_elig;
    logic               w_grant_vld;
    logic [PTR_W-1:0]   w_grant_idx;
    int                 w_scan;
    logic               w_pass;

`ifdef SR_LATCH_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    logic [RTY_W-1:0]   r_retry, w_nxt_retry;
`endif

    assign w_pass = (bus.q == r_op) && (bus.q_n == ~r_op);

    // The requester acked this cycle is masked so it cannot win twice in a row.
    always_comb begin
        w_elig      = bus.req & ~r_ack;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_scan = (int'(r_ptr) + i) % N_REQ;
            if (!w_grant_vld && w_elig[w_scan]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = PTR_W'(w_scan);
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_ptr   = r_ptr;
        w_nxt_op    = r_op;
        w_nxt_s     = 1'b0;
        w_nxt_r     = 1'b0;
        w_nxt_ack   = '0;
        w_nxt_ok    = 1'b0;
        w_nxt_err   = 1'b0;
`ifdef SR_LATCH_RETRY_EN
        w_nxt_retry = r_retry;
`endif
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_nxt_state = DRIVE;
                    w_nxt_ptr   = w_grant_idx;
                    w_nxt_op    = bus.op[w_grant_idx];
                    w_nxt_cnt   = PULSE_LD;
                    w_nxt_s     = bus.op[w_grant_idx];
                    w_nxt_r     = ~bus.op[w_grant_idx];
`ifdef SR_LATCH_RETRY_EN
                    w_nxt_retry = '0;
`endif
                end
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    w_nxt_state = SETTLE;
                    w_nxt_cnt   = SETTLE_LD;
                end else begin
                    w_nxt_cnt = r_cnt - 1'b1;
                    w_nxt_s   = r_op;
                    w_nxt_r   = ~r_op;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_nxt_state = CHECK;
                end else begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end
            end
            CHECK: begin
`ifdef SR_LATCH_RETRY_EN
                if (!w_pass && (r_retry < RTY_MAX)) begin
                    w_nxt_state = DRIVE;
                    w_nxt_retry = r_retry + 1'b1;
                    w_nxt_cnt   = PULSE_LD;
                    w_nxt_s     = r_op;
                    w_nxt_r     = ~r_op;
                end else begin
                    w_nxt_state        = IDLE;
                    w_nxt_ack[r_ptr]   = 1'b1;
                    w_nxt_ok           = w_pass;
                    w_nxt_err          = ~w_pass;
                end
`else
                w_nxt_state      = IDLE;
                w_nxt_ack[r_ptr] = 1'b1;
                w_nxt_ok         = w_pass;
                w_nxt_err        = ~w_pass;
`endif
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= PTR_RST;
            r_op    <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_ack   <= '0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef SR_LATCH_RETRY_EN
            r_retry <= '0;
`endif
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_ptr   <= w_nxt_ptr;
            r_op    <= w_nxt_op;
            r_s     <= w_nxt_s;
            r_r     <= w_nxt_r;
            r_ack   <= w_nxt_ack;
            r_ok    <= w_nxt_ok;
            r_err   <= w_nxt_err;
            r_busy  <= (w_nxt_state != IDLE);
`ifdef SR_LATCH_RETRY_EN
            r_retry <= w_nxt_retry;
`endif
        end
    end

    assign bus.s    = r_s;
    assign bus.r    = r_r;
    assign bus.ack  = r_ack;
    assign bus.ok   = r_ok;
    assign bus.err  = r_err;
    assign bus.busy = r_busy;

endmodule
